alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered successor to the 3-bit combinational ALU: WIDTH-bit operands,
//  eight opcodes incl. shifts and an iterative unsigned multiply, status flags, an
//  accumulator operand source and valid/ready handshakes on both sides. Sits between an
//  operand-issuing controller and a result consumer in the same clock domain.
// PARAMETERS
//  WIDTH   8  operand width, >=2; result is 2*WIDTH bits
//  MUL_EN  1  1 = MUL implemented; 0 = MUL opcode behaves as reserved
//  (localparam SHW = $clog2(WIDTH): shift-amount width)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operand/opcode valid
//  in_ready   out  1        block accepts an operation this cycle
//  a          in   WIDTH    operand A (ignored when use_acc=1)
//  b          in   WIDTH    operand B
//  opcode     in   3        000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 SHL,110 SHR,111 MUL
//  use_acc    in   1        1 = substitute accumulator for A
//  out_valid  out  1        result/flags valid
//  out_ready  in   1        consumer takes result this cycle
//  result     out  2*WIDTH  result, zero-extended unless stated
//  flag_c     out  1        carry / borrow / last bit shifted out
//  flag_z     out  1        result == 0 over all 2*WIDTH bits
//  flag_v     out  1        signed overflow (ADD/SUB only, else 0)
// BEHAVIOUR
//  Reset: in_ready=0 while rst_n low; out_valid=0, result=0, flags=0, acc=0, FSM=IDLE.
//  FSM: IDLE -> (accept MUL) MUL -> (WIDTH iterations done) IDLE. Other ops stay IDLE.
//  in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  Single-cycle ops: accepted at edge t -> result/flags registered at t, out_valid high from t.
//   Back-to-back accepts allowed (throughput 1/cycle when out_ready=1).
//  MUL: operands latched at accept edge t; one shift-add iteration per edge;
//   result registered and out_valid high from edge t+WIDTH; in_ready=0 throughout.
//  Output hold: while out_valid && !out_ready, result/flags/out_valid stable.
//   out_valid drops on handshake unless a new op is accepted the same edge.
//  acc <= result[WIDTH-1:0] whenever a result is registered (not on handshake).
//  ADD: result[WIDTH:0] = A+B; flag_c = result[WIDTH]; flag_v = signed ovf.
//  SUB: result[WIDTH-1:0] = A-B mod 2^WIDTH; result[WIDTH] = flag_c = borrow (A<B); flag_v signed ovf.
//  AND/OR/XOR: bitwise, upper bits 0, flag_c=0.
//  SHL/SHR: logical by b[SHW-1:0]; low WIDTH bits only; flag_c = last bit shifted out, 0 if amount 0.
//  MUL: unsigned 2*WIDTH product, flag_c=0. With MUL_EN=0: result 0, flag_z=1, 1-cycle.
//  flag_z always computed on registered result.
//  Reset mid-MUL: asynchronously aborts; no result emitted after release.
//  in_valid while in_ready=0: ignored; source must hold per valid/ready rules.
// STRUCTURE
//  alu_pkg: opcode localparams (OP_ADD..OP_MUL), FSM state encodings (ST_IDLE, ST_MUL).
//  Sub-module alu_mul_iter: iterative shift-add multiplier (start, done, product);
//   the remaining ops, flags, FSM and handshake stay in alu_seq.
// TESTING (WIDTH=8)
//  ADD 200+100, out_ready=1 -> next cycle result=0x012C, flag_c=1, flag_z=0; SUB 5-7 -> 0x01FE, flag_c=1.
//  ADD 0x7F+0x01 -> result 0x0080, flag_v=1, flag_c=0; AND 0xF0&0x0F -> 0, flag_z=1.
//  MUL 0xFF*0xFF -> in_ready low 8 cycles, result 0xFE01 exactly 8 edges after accept.
//  out_ready=0 after ADD 1+2 -> result 3 held, in_ready=0; out_ready=1 -> one handshake, no dup.
//  use_acc chain: ADD 3+4, then use_acc=1 ADD b=10 -> 17; SHL acc by 4 -> 0x0010, flag_c=1.
//  Assert rst_n=0 mid-MUL -> out_valid=0 immediately, no result after release, acc=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   opcode_e : operation encodings carried on the 3-bit opcode port
//   state_e  : control FSM states of alu_seq
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier.
//   clk, rst_n : clock, asynchronous active-low reset (aborts a multiply in flight)
//   start      : latch a/b and begin; one partial-product step per following edge
//   a, b       : WIDTH-bit unsigned operands
//   done       : high in the cycle whose rising edge completes the last iteration
//   product    : 2*WIDTH-bit product, valid while done is high
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;

  // product is the accumulator value after the current edge's iteration, so
  // the consumer can register the final result on the same edge done is seen.
  always_comb begin
    prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product = prod_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      prod_q   <= '0;
    end else if (busy_q) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with status flags, accumulator operand source and
// valid/ready handshakes on input and output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake (a, b, opcode, use_acc)
//   a, b                : operands; use_acc=1 substitutes the accumulator for a
//   opcode              : ADD SUB AND OR XOR SHL SHR MUL
//   out_valid/out_ready : result handshake
//   result              : 2*WIDTH-bit result, zero-extended unless noted
//   flag_c/flag_z/flag_v: carry-borrow-shiftout / zero / signed overflow
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  input  logic               use_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_c,
  output logic               flag_z,
  output logic               flag_v
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned RW  = 2 * WIDTH;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [RW-1:0]    result_q, result_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_v_q, flag_v_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  opcode_e          op;
  logic             accept;
  logic             start_mul;
  logic             mul_done;
  logic [RW-1:0]    mul_prod;

  logic [WIDTH-1:0] op_a;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH:0]   shl_w, shr_w;
  logic [RW-1:0]    alu_res;
  logic             alu_c, alu_v;

  assign op        = opcode_e'(opcode);
  assign in_ready  = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && (op == OP_MUL) && MUL_EN;

  if (MUL_EN) begin : g_mul
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_mul),
      .a       (op_a),
      .b       (b),
      .done    (mul_done),
      .product (mul_prod)
    );
  end else begin : g_nomul
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  // Single-cycle datapath. Shifts run one bit wider than the operand so the
  // extra bit captures the last bit shifted out (and is 0 for amount 0).
  always_comb begin
    op_a  = use_acc ? acc_q : a;
    shamt = b[SHW-1:0];
    sum   = {1'b0, op_a} + {1'b0, b};
    diff  = {1'b0, op_a} - {1'b0, b};
    shl_w = {1'b0, op_a} << shamt;
    shr_w = {op_a, 1'b0} >> shamt;

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = {{(WIDTH-1){1'b0}}, sum};
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = {{(WIDTH-1){1'b0}}, diff};
        alu_c   = diff[WIDTH];
        alu_v   = (op_a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND: alu_res = {{WIDTH{1'b0}}, op_a & b};
      OP_OR:  alu_res = {{WIDTH{1'b0}}, op_a | b};
      OP_XOR: alu_res = {{WIDTH{1'b0}}, op_a ^ b};
      OP_SHL: begin
        alu_res = {{WIDTH{1'b0}}, shl_w[WIDTH-1:0]};
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = {{WIDTH{1'b0}}, shr_w[WIDTH:1]};
        alu_c   = shr_w[0];
      end
      default: ; // OP_MUL reaches here only when the multiplier is absent: result 0
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    flag_v_d    = flag_v_q;
    acc_d       = acc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (start_mul) begin
            state_d     = ST_MUL;
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            flag_c_d    = alu_c;
            flag_z_d    = (alu_res == '0);
            flag_v_d    = alu_v;
            acc_d       = alu_res[WIDTH-1:0];
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          result_d    = mul_prod;
          flag_c_d    = 1'b0;
          flag_z_d    = (mul_prod == '0);
          flag_v_d    = 1'b0;
          acc_d       = mul_prod[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      flag_v_q    <= flag_v_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int unsigned W = 8;

  localparam logic [2:0] O_ADD = 3'd0;
  localparam logic [2:0] O_SUB = 3'd1;
  localparam logic [2:0] O_AND = 3'd2;
  localparam logic [2:0] O_OR  = 3'd3;
  localparam logic [2:0] O_XOR = 3'd4;
  localparam logic [2:0] O_SHL = 3'd5;
  localparam logic [2:0] O_SHR = 3'd6;
  localparam logic [2:0] O_MUL = 3'd7;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2:0]     opcode = '0;
  logic           use_acc = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           flag_c, flag_z, flag_v;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_v    (flag_v)
  );

  typedef struct {
    logic [2:0]     op;
    logic [W-1:0]   av;
    logic [W-1:0]   bv;
    logic           ua;
    logic [2*W-1:0] res;
    logic           cf;
    logic           zf;
    logic           vf;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] res;
    logic           cf;
    logic           zf;
    logic           vf;
  } exp_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic ua);
    opcode   = op;
    a        = av;
    b        = bv;
    use_acc  = ua;
    in_valid = 1'b1;
  endtask

  // Reference: plain integer arithmetic on unsigned / two's-complement values.
  function automatic exp_t ref_op(input logic [2:0] op, input int unsigned x, input int unsigned y);
    exp_t e;
    int sx, sy, s;
    int unsigned amt, r;
    sx  = (x >= 128) ? int'(x) - 256 : int'(x);
    sy  = (y >= 128) ? int'(y) - 256 : int'(y);
    amt = y % W;
    r   = 0;
    e.cf = 1'b0;
    e.vf = 1'b0;
    case (op)
      O_ADD: begin r = x + y; e.cf = (r >= 256); s = sx + sy; e.vf = (s > 127) || (s < -128); end
      O_SUB: begin
        r = ((x - y) & 32'd255) | ((x < y) ? 32'd256 : 32'd0);
        e.cf = (x < y); s = sx - sy; e.vf = (s > 127) || (s < -128);
      end
      O_AND: r = x & y;
      O_OR:  r = x | y;
      O_XOR: r = x ^ y;
      O_SHL: begin r = (x << amt) & 32'd255; e.cf = (amt != 0) && (((x >> (W - amt)) & 1) != 0); end
      O_SHR: begin r = x >> amt; e.cf = (amt != 0) && (((x >> (amt - 1)) & 1) != 0); end
      default: r = x * y;
    endcase
    e.res = r[2*W-1:0];
    e.zf  = (r == 0);
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit             got;
    int             n;
    bit             hold;
    bit             exp_ready;
    bit             acc_now;
    bit             m_valid;
    int             m_left;
    exp_t           m_out, m_pend, e;
    logic [W-1:0]   m_acc;

    vecs[0]  = '{O_ADD, 8'd200, 8'd100, 1'b0, 16'h012C, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{O_SUB, 8'd5,   8'd7,   1'b0, 16'h01FE, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{O_ADD, 8'h7F,  8'h01,  1'b0, 16'h0080, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{O_AND, 8'hF0,  8'h0F,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{O_OR,  8'hF0,  8'h0F,  1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{O_XOR, 8'hAA,  8'hFF,  1'b0, 16'h0055, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{O_SHR, 8'h81,  8'd1,   1'b0, 16'h0040, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{O_SHL, 8'h81,  8'd0,   1'b0, 16'h0081, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{O_SUB, 8'h80,  8'h01,  1'b0, 16'h007F, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{O_ADD, 8'd3,   8'd4,   1'b0, 16'h0007, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{O_ADD, 8'hEE,  8'd10,  1'b1, 16'h0011, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{O_SHL, 8'h00,  8'd4,   1'b1, 16'h0010, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{O_SHR, 8'h80,  8'd7,   1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{O_ADD, 8'hFF,  8'h01,  1'b0, 16'h0100, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{O_SUB, 8'h00,  8'h00,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};

    // Reset state, with an operation offered while reset is asserted.
    drive(O_ADD, 8'd1, 8'd1, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_flags", 32'({flag_c, flag_z, flag_v}), 32'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_out_valid", 32'(out_valid), 32'(0));

    // Table vectors, issued back to back with out_ready held high.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].ua);
      out_ready = 1'b1;
      #1;
      check("tbl_in_ready", 32'(in_ready), 32'(1));
      step();
      check("tbl_out_valid", 32'(out_valid), 32'(1));
      check("tbl_result", 32'(result), 32'(vecs[i].res));
      check("tbl_flags", 32'({flag_c, flag_z, flag_v}),
            32'({vecs[i].cf, vecs[i].zf, vecs[i].vf}));
    end
    in_valid = 1'b0;
    step();
    check("tbl_drain", 32'(out_valid), 32'(0));

    // MUL 0xFF*0xFF: busy for WIDTH edges, result exactly WIDTH edges after accept.
    drive(O_MUL, 8'hFF, 8'hFF, 1'b0);
    #1;
    check("mul_accept_ready", 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
    got = 1'b0;
    n = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (!out_valid) check("mul_busy_ready", 32'(in_ready), 32'(0));
      step();
      if (out_valid) begin
        got = 1'b1;
        n = k;
      end
    end
    check("mul_latency", 32'(n), 32'(W));
    check("mul_result", 32'(result), 32'h0000FE01);
    check("mul_flags", 32'({flag_c, flag_z, flag_v}), 32'(0));
    drive(O_ADD, 8'h00, 8'h00, 1'b1);
    #1;
    step();
    check("mul_acc", 32'(result), 32'h00000001);
    in_valid = 1'b0;
    step();

    // Output hold under back-pressure, single handshake.
    out_ready = 1'b0;
    drive(O_ADD, 8'd1, 8'd2, 1'b0);
    #1;
    check("hold_accept_ready", 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("hold_valid", 32'(out_valid), 32'(1));
      check("hold_result", 32'(result), 32'(3));
      check("hold_in_ready", 32'(in_ready), 32'(0));
      step();
    end
    out_ready = 1'b1;
    #1;
    check("hold_release_ready", 32'(in_ready), 32'(1));
    step();
    check("hold_handshake", 32'(out_valid), 32'(0));
    step();
    check("hold_no_dup", 32'(out_valid), 32'(0));

    // Reset in the middle of a multiply.
    drive(O_MUL, 8'd3, 8'd5, 1'b0);
    #1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_in_ready", 32'(in_ready), 32'(0));
    check("abort_result", 32'(result), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("abort_no_result", 32'(out_valid), 32'(0));
    end
    drive(O_ADD, 8'h55, 8'h00, 1'b1);
    #1;
    check("abort_ready", 32'(in_ready), 32'(1));
    step();
    check("abort_acc", 32'(result), 32'(0));
    check("abort_acc_z", 32'(flag_z), 32'(1));
    in_valid = 1'b0;
    step();

    // Randomized traffic against a transaction-level model.
    m_valid = 1'b0;
    m_left  = 0;
    m_acc   = '0;
    m_out   = '{default: '0};
    m_pend  = '{default: '0};
    hold    = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        opcode   = 3'($urandom_range(0, 7));
        a        = W'($urandom);
        b        = W'($urandom);
        use_acc  = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = (m_left == 0) && (!m_valid || out_ready);
      check("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
      acc_now = in_valid && exp_ready;
      if (acc_now) begin
        e = ref_op(opcode, use_acc ? m_acc : a, b);
        if (opcode == O_MUL) begin
          m_left  = W;
          m_valid = 1'b0;
          m_pend  = e;
        end else begin
          m_valid = 1'b1;
          m_out   = e;
          m_acc   = e.res[W-1:0];
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1'b1;
          m_out   = m_pend;
          m_acc   = m_pend.res[W-1:0];
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      hold = in_valid && !acc_now;
      step();
      check("rnd_out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("rnd_result", 32'(result), 32'(m_out.res));
        check("rnd_flags", 32'({flag_c, flag_z, flag_v}), 32'({m_out.cf, m_out.zf, m_out.vf}));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
